// File: rtl/nlprg10_pkg.sv
// Shared constants for the 10-bit nonlinear (de Bruijn) pattern generator.
// N      : state width
// TAP_HI : upper feedback tap, the bit shifted out of the register
// TAP_LO : lower feedback tap
// SEED   : reset value of the state register
package nlprg10_pkg;

  localparam int N      = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;

  typedef logic [N-1:0] state_t;

  localparam state_t SEED = '0;

endpackage

// File: rtl/nlprg10_if.sv
// Output bus of the nlprg10 generator.
// o : current generator state (driven by master, observed by slave)
interface nlprg10_if;

  logic [nlprg10_pkg::N-1:0] o;

  modport master (output o);
  modport slave  (input  o);

endinterface

// File: rtl/nlprg10_fb.sv
// nlprg_fb: combinational feedback for the de Bruijn generator.
// s  : current state
// fb : bit to shift in at position 0
// The linear part s[9]^s[6] alone is a 1023-state maximal LFSR. The z term
// fires whenever s[8:0] is all zero, which is only true in 0x200 and 0x000.
// It flips the feedback in exactly those two states, splicing the all-zero
// state in between 0x200 and 0x001 and giving a full 1024-state cycle.
module nlprg_fb
  import nlprg10_pkg::*;
(
  input  state_t s,
  output logic   fb
);

  logic z;

  assign z  = (s[N-2:0] == '0);
  assign fb = s[TAP_HI] ^ s[TAP_LO] ^ z;

endmodule

// File: rtl/nlprg10.sv
// nlprg10: free-running 10-bit de Bruijn sequence generator.
// ck  : clock, state updates on the rising edge
// rst : asynchronous active-low reset, forces the state to SEED
// bus : nlprg10_if master, bus.o is the state register itself
// The top level holds only the state register and its shift. All feedback
// logic is in nlprg_fb.
module nlprg10
  import nlprg10_pkg::*;
(
  input  logic       ck,
  input  logic       rst,
  nlprg10_if.master  bus
);

  state_t s;
  logic   fb;

  nlprg_fb u_fb (
    .s  (s),
    .fb (fb)
  );

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      s <= SEED;
    end else begin
      s <= {s[N-2:0], fb};
    end
  end

  assign bus.o = s;

endmodule

// File: tb/tb_nlprg10.sv
// Self-checking bench for nlprg10. The reference model computes the next
// state arithmetically from the generator's defining rule: double modulo
// 1024, then add the feedback bit (tap parity, inverted when the low nine
// bits are zero).
`timescale 1ns/1ps
module tb_nlprg10;

  logic ck;
  logic rst;

  nlprg10_if bus ();

  nlprg10 dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  int assert_cnt;
  int fail_cnt;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int start_seq [11] = '{'h001, 'h002, 'h004, 'h008, 'h010, 'h020,
                         'h040, 'h081, 'h102, 'h204, 'h009};

  function automatic int model_next(input int v);
    int lin;
    int z;
    lin = ((v / 512) % 2) ^ ((v / 64) % 2);
    z   = ((v % 512) == 0) ? 1 : 0;
    return ((v * 2) % 1024) + (lin ^ z);
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive reset low for two cycles, then release on a falling edge.
  task automatic apply_reset();
    @(negedge ck);
    rst = 1'b0;
    repeat (2) @(negedge ck);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) begin
      @(negedge ck);
      cmp("reset_hold", int'(bus.o), 0);
    end
    rst = 1'b1;
    repeat (7) @(negedge ck);
    if (bus.o == '0) begin
      assert_cnt++;
      fail_cnt++;
      $display("FAIL reset_prerun: got %03h expected nonzero", bus.o);
    end
    // Assert reset between edges; the output must clear with no clock edge.
    @(posedge ck);
    #2;
    rst = 1'b0;
    #1;
    cmp("reset_async", int'(bus.o), 0);
    @(negedge ck);
    cmp("reset_async_hold", int'(bus.o), 0);
    rst = 1'b1;
  endtask

  task automatic test_start_sequence();
    apply_reset();
    cmp("start_seed", int'(bus.o), 0);
    for (int i = 0; i < 11; i++) begin
      @(negedge ck);
      cmp($sformatf("start_seq[%0d]", i), int'(bus.o), start_seq[i]);
    end
  endtask

  task automatic test_full_period();
    int cnt;
    int exp;
    apply_reset();
    cnt = 0;
    exp = 0;
    cmp("period_seed", int'(bus.o), exp);
    for (int i = 0; i < 2048; i++) begin
      @(negedge ck);
      cnt = (cnt + 1) % 1024;
      exp = model_next(exp);
      cmp("period_model", int'(bus.o), exp);
      cmp("period_zero_iff_cnt0", (bus.o == '0) ? 1 : 0, (cnt == 0) ? 1 : 0);
    end
  endtask

  task automatic test_uniqueness();
    bit seen [1024];
    int distinct;
    apply_reset();
    distinct = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i != 0) @(negedge ck);
      if (!seen[int'(bus.o)]) begin
        seen[int'(bus.o)] = 1'b1;
        distinct++;
      end
    end
    cmp("unique_count", distinct, 1024);
  endtask

  task automatic test_zero_insertion();
    bit found;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      @(negedge ck);
      if (bus.o == 10'h200) found = 1'b1;
    end
    if (!found) begin
      assert_cnt++;
      fail_cnt++;
      $display("FAIL zero_find: got no 200 within 1100 cycles expected 200");
    end else begin
      @(negedge ck);
      cmp("zero_after_200", int'(bus.o), 'h000);
      @(negedge ck);
      cmp("one_after_000", int'(bus.o), 'h001);
    end
  endtask

  task automatic test_midrun_reset();
    apply_reset();
    repeat (500) @(negedge ck);
    rst = 1'b0;
    #1;
    cmp("mid_reset_clear", int'(bus.o), 0);
    @(negedge ck);
    cmp("mid_reset_hold", int'(bus.o), 0);
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge ck);
      cmp($sformatf("mid_restart[%0d]", i), int'(bus.o), start_seq[i]);
    end
  endtask

  // Random run lengths and random reset timing within the cycle.
  task automatic test_random_resets();
    int exp;
    int len;
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      exp = 0;
      len = $urandom_range(1, 1500);
      for (int i = 0; i < len; i++) begin
        @(negedge ck);
        exp = model_next(exp);
      end
      cmp("rand_state", int'(bus.o), exp);
      #($urandom_range(1, 8));
      rst = 1'b0;
      #0.5;
      cmp("rand_async_clear", int'(bus.o), 0);
      @(negedge ck);
      rst = 1'b1;
      @(negedge ck);
      cmp("rand_first_edge", int'(bus.o), 'h001);
    end
  endtask

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b0;
    test_reset();
    test_start_sequence();
    test_full_period();
    test_uniqueness();
    test_zero_insertion();
    test_midrun_reset();
    test_random_resets();
    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_cnt, fail_cnt);
    $finish;
  end

endmodule
